// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: feeds word indices to a decompression stage and buffers
// the expanded instructions for the core. Optional macro FETCH_COUNT_EN adds a handshake counter.
module instr_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] dec_pc,
    input  logic [31:0] dec_instr,
    output logic        core_valid,
    input  logic        core_ready,
    output logic [31:0] core_instr,
    output logic [31:0] core_pc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
`ifdef FETCH_COUNT_EN
    ,
    output logic [31:0] fetch_count
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_next_s;
    logic            run_s;
    logic [PW-1:0]   head_r;
    logic [PW-1:0]   tail_r;
    logic [CW-1:0]   count_r;
    logic [CW-1:0]   count_next_s;
    logic [31:0]     dec_pc_r;
    logic            full_s;
    logic            empty_s;
    logic            pop_s;
    logic            push_s;
    logic [31:0]     mem_pc_r    [DEPTH];
    logic [31:0]     mem_instr_r [DEPTH];

    assign full_s     = (count_r == CW'(DEPTH));
    assign empty_s    = (count_r == {CW{1'b0}});
    assign core_valid = ~empty_s;
    assign pop_s      = core_valid & core_ready;
    // A redirect cancels any push in the same cycle; a pop frees a slot even when full.
    assign push_s     = run_s & (~full_s | pop_s) & ~redirect;
    assign dec_pc     = dec_pc_r;
    assign core_pc    = core_valid ? mem_pc_r[head_r]    : 32'h0000_0000;
    assign core_instr = core_valid ? mem_instr_r[head_r] : 32'h0000_0000;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE:    state_next_s = RUN;
            RUN:     state_next_s = redirect ? FLUSH : RUN;
            FLUSH:   state_next_s = redirect ? FLUSH : RUN;
            default: state_next_s = IDLE;
        endcase
    end

    // State-decoded fetch enable; FLUSH gives the decompressor a bubble cycle
    always_comb begin
        run_s = 1'b0;
        case (state_r)
            IDLE:    run_s = 1'b0;
            RUN:     run_s = 1'b1;
            FLUSH:   run_s = 1'b0;
            default: run_s = 1'b0;
        endcase
    end

    // Occupancy update for the non-redirect case
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CW'(1'b1);
            2'b01:   count_next_s = count_r - CW'(1'b1);
            default: count_next_s = count_r;
        endcase
    end

    // Pointers, occupancy and fetch PC; redirect flushes and wins over push/pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_r   <= {PW{1'b0}};
            tail_r   <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
            dec_pc_r <= RESET_PC;
        end else if (redirect) begin
            head_r   <= {PW{1'b0}};
            tail_r   <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
            dec_pc_r <= redirect_pc;
        end else begin
            count_r <= count_next_s;
            if (push_s) begin
                tail_r   <= tail_r + PW'(1'b1);
                dec_pc_r <= dec_pc_r + 32'd1;
            end
            if (pop_s) begin
                head_r <= head_r + PW'(1'b1);
            end
        end
    end

    // Entry storage; contents are only observable through a valid head
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_pc_r[tail_r]    <= dec_pc_r;
            mem_instr_r[tail_r] <= dec_instr;
        end
    end

`ifdef FETCH_COUNT_EN
    logic [31:0] fetch_count_r;
    assign fetch_count = fetch_count_r;

    // Accepted-handshake counter; a head dropped by redirect is not counted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_count_r <= 32'd0;
        end else if (pop_s & ~redirect) begin
            fetch_count_r <= fetch_count_r + 32'd1;
        end else begin
            fetch_count_r <= fetch_count_r;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomized self-checking bench for instr_fetch_queue against a queue-based reference model.
module tb_instr_fetch_queue;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] dec_pc;
    logic [31:0] dec_instr;
    logic        core_valid;
    logic        core_ready = 1'b0;
    logic [31:0] core_instr;
    logic [31:0] core_pc;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0000_0000;
`ifdef FETCH_COUNT_EN
    logic [31:0] fetch_count;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: in-order list of queued word indices plus fetch pointer
    logic [31:0] q_pc[$];
    logic [31:0] m_pc;
    logic [31:0] m_count;
    bit          m_started;
    bit          m_bubble;

    assign dec_instr = 32'h1000_0000 + dec_pc;

    always #5 clk = ~clk;

    instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk         (clk),
        .rst         (rst),
        .dec_pc      (dec_pc),
        .dec_instr   (dec_instr),
        .core_valid  (core_valid),
        .core_ready  (core_ready),
        .core_instr  (core_instr),
        .core_pc     (core_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
`ifdef FETCH_COUNT_EN
        ,
        .fetch_count (fetch_count)
`endif
    );

    task automatic model_reset();
        q_pc.delete();
        m_pc      = RPC;
        m_count   = 32'd0;
        m_started = 1'b0;
        m_bubble  = 1'b0;
    endtask

    // One clock edge with the currently driven inputs; model advances in step
    task automatic step();
        bit do_pop;
        bit do_push;
        @(posedge clk);
        if (redirect) begin
            q_pc.delete();
            m_pc     = redirect_pc;
            m_bubble = 1'b1;
        end else if (!m_started) begin
            m_started = 1'b1;
        end else if (m_bubble) begin
            m_bubble = 1'b0;
        end else begin
            do_pop  = (q_pc.size() > 0) && core_ready;
            do_push = (q_pc.size() < DEPTH) || do_pop;
            if (do_pop) begin
                void'(q_pc.pop_front());
                m_count = m_count + 32'd1;
            end
            if (do_push) begin
                q_pc.push_back(m_pc);
                m_pc = m_pc + 32'd1;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        redirect = 1'b0;
        core_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (core_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", core_valid); end
        checks++; if (core_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0", core_pc); end
        checks++; if (core_instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected 0", core_instr); end
        checks++; if (dec_pc !== RPC) begin errors++; $display("FAIL reset_dec_pc: got %h expected %h", dec_pc, RPC); end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_stream();
        core_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++; if (core_valid !== (q_pc.size() != 0)) begin errors++; $display("FAIL stream_valid cyc %0d: got %b expected %b", i, core_valid, q_pc.size() != 0); end
            if (q_pc.size() != 0) begin
                checks++; if (core_pc !== q_pc[0]) begin errors++; $display("FAIL stream_pc cyc %0d: got %h expected %h", i, core_pc, q_pc[0]); end
                checks++; if (core_instr !== 32'h1000_0000 + q_pc[0]) begin errors++; $display("FAIL stream_instr cyc %0d: got %h expected %h", i, core_instr, 32'h1000_0000 + q_pc[0]); end
            end
        end
    endtask

    task automatic test_stall_and_full();
        logic [31:0] prev_dec;
        do_reset();
        for (int i = 0; i < 10; i++) step();
        checks++; if (dec_pc !== 32'd4) begin errors++; $display("FAIL stall_dec_pc: got %h expected 4", dec_pc); end
        checks++; if (core_valid !== 1'b1 || core_pc !== 32'd0) begin errors++; $display("FAIL stall_head: got v=%b pc=%h expected v=1 pc=0", core_valid, core_pc); end
        core_ready = 1'b1;
        prev_dec = dec_pc;
        for (int i = 0; i < 12; i++) begin
            step();
            checks++; if (core_valid !== 1'b1 || core_pc !== q_pc[0]) begin errors++; $display("FAIL full_head cyc %0d: got v=%b pc=%h expected v=1 pc=%h", i, core_valid, core_pc, q_pc[0]); end
            checks++; if (dec_pc !== prev_dec + 32'd1) begin errors++; $display("FAIL full_push cyc %0d: got %h expected %h", i, dec_pc, prev_dec + 32'd1); end
            prev_dec = dec_pc;
        end
    endtask

    task automatic test_redirect();
        int waited;
        do_reset();
        for (int i = 0; i < 4; i++) step();
        checks++; if (core_valid !== 1'b1 || core_pc !== 32'd0) begin errors++; $display("FAIL redir_pre: got v=%b pc=%h expected v=1 pc=0", core_valid, core_pc); end
        redirect = 1'b1;
        redirect_pc = 32'h0000_0020;
        core_ready = 1'b1;
        step();
        redirect = 1'b0;
        checks++; if (core_valid !== 1'b0) begin errors++; $display("FAIL redir_valid: got %b expected 0", core_valid); end
        checks++; if (dec_pc !== 32'h20) begin errors++; $display("FAIL redir_dec_pc: got %h expected 20", dec_pc); end
        waited = 0;
        while (core_valid !== 1'b1 && waited < 6) begin
            step();
            waited++;
        end
        checks++; if (waited != 2) begin errors++; $display("FAIL redir_latency: got %0d cycles expected 2", waited); end
        checks++; if (core_pc !== 32'h20) begin errors++; $display("FAIL redir_head_pc: got %h expected 20", core_pc); end
    endtask

    task automatic test_wrap();
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        core_ready = 1'b1;
        step();
        redirect = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++; if (dec_pc !== m_pc) begin errors++; $display("FAIL wrap_dec_pc cyc %0d: got %h expected %h", i, dec_pc, m_pc); end
            if (q_pc.size() != 0) begin
                checks++; if (core_pc !== q_pc[0]) begin errors++; $display("FAIL wrap_pc cyc %0d: got %h expected %h", i, core_pc, q_pc[0]); end
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 3; i++) step();
        checks++; if (core_valid !== 1'b1) begin errors++; $display("FAIL areset_pre: got %b expected 1", core_valid); end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (core_valid !== 1'b0) begin errors++; $display("FAIL areset_valid: got %b expected 0", core_valid); end
        checks++; if (dec_pc !== RPC) begin errors++; $display("FAIL areset_dec_pc: got %h expected %h", dec_pc, RPC); end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        core_ready = 1'b1;
        step();
        step();
        checks++; if (core_valid !== 1'b1 || core_pc !== RPC) begin errors++; $display("FAIL areset_first: got v=%b pc=%h expected v=1 pc=%h", core_valid, core_pc, RPC); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            core_ready = ($urandom_range(0, 3) != 0);
            redirect   = ($urandom_range(0, 19) == 0);
            redirect_pc = ($urandom_range(0, 1) == 0) ? $urandom : (32'hFFFF_FFFC + 32'($urandom_range(0, 3)));
            step();
            checks++; if (core_valid !== (q_pc.size() != 0)) begin errors++; $display("FAIL rand_valid cyc %0d: got %b expected %b", i, core_valid, q_pc.size() != 0); end
            checks++; if (dec_pc !== m_pc) begin errors++; $display("FAIL rand_dec_pc cyc %0d: got %h expected %h", i, dec_pc, m_pc); end
            if (q_pc.size() != 0) begin
                checks++; if (core_pc !== q_pc[0] || core_instr !== 32'h1000_0000 + q_pc[0]) begin errors++; $display("FAIL rand_head cyc %0d: got %h/%h expected %h/%h", i, core_pc, core_instr, q_pc[0], 32'h1000_0000 + q_pc[0]); end
            end
`ifdef FETCH_COUNT_EN
            checks++; if (fetch_count !== m_count) begin errors++; $display("FAIL rand_fetch_count cyc %0d: got %0d expected %0d", i, fetch_count, m_count); end
`endif
        end
        redirect = 1'b0;
    endtask

`ifdef FETCH_COUNT_EN
    task automatic test_fetch_count();
        int guard;
        do_reset();
        core_ready = 1'b1;
        guard = 0;
        while (m_count < 32'd10 && guard < 30) begin
            step();
            guard++;
        end
        checks++; if (fetch_count !== 32'd10) begin errors++; $display("FAIL fc_ten: got %0d expected 10", fetch_count); end
        redirect = 1'b1;
        redirect_pc = 32'h0000_0100;
        step();
        redirect = 1'b0;
        core_ready = 1'b0;
        repeat (3) step();
        checks++; if (fetch_count !== 32'd10) begin errors++; $display("FAIL fc_after_redirect: got %0d expected 10", fetch_count); end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_stream();
        test_stall_and_full();
        test_redirect();
        test_wrap();
        test_async_reset();
        test_random();
`ifdef FETCH_COUNT_EN
        test_fetch_count();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving queue entries; it SHALL be a power of two and at least 2.
REQ-002 The block SHALL have parameter RESET_PC, default 32'h00000000, giving the first fetch word index after reset.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port dec_pc, output, 32 bits: word index presented to the decompression stage.
REQ-006 The block SHALL have port dec_instr, input, 32 bits: expanded instruction returned by the decompression stage for the current dec_pc, valid in the same cycle.
REQ-007 The block SHALL have port core_valid, output, 1 bit: the head entry is valid.
REQ-008 The block SHALL have port core_ready, input, 1 bit: the core accepts the head entry.
REQ-009 The block SHALL have port core_instr, output, 32 bits: instruction of the head entry.
REQ-010 The block SHALL have port core_pc, output, 32 bits: word index of the head entry.
REQ-011 The block SHALL have port redirect, input, 1 bit: a one-cycle flush-and-jump request.
REQ-012 The block SHALL have port redirect_pc, input, 32 bits: target word index, sampled when redirect is high.

Function
REQ-013 The block SHALL implement a state machine with states IDLE, RUN and FLUSH.
REQ-014 The state machine SHALL transition IDLE->RUN unconditionally, RUN->FLUSH on redirect and FLUSH->RUN when redirect is low; redirect in FLUSH SHALL reload the target and remain in FLUSH.
REQ-015 dec_pc SHALL be a register, SHALL change only on a push or a redirect, and SHALL hold stable during stalls, because the decompression stage advances its internal state on every dec_pc change.
REQ-016 pop SHALL equal core_valid AND core_ready, and push SHALL equal state==RUN AND (not full OR pop) AND NOT redirect.
REQ-017 A push SHALL write {dec_pc, dec_instr} at the tail and SHALL increment dec_pc by 1, wrapping from 32'hFFFFFFFF to 0.
REQ-018 A pop SHALL advance the head; core_valid SHALL equal NOT empty; core_instr and core_pc SHALL be driven from the head entry.
REQ-019 An entry pushed at edge N SHALL be visible at the head no earlier than the cycle following edge N.
REQ-020 A simultaneous push and pop SHALL leave the occupancy unchanged, including when the queue is full, sustaining one instruction per cycle.
REQ-021 The occupancy counter SHALL be $clog2(DEPTH)+1 bits wide, and the pointers SHALL be $clog2(DEPTH) bits wide, wrapping naturally.
REQ-022 On redirect, the block SHALL empty the queue, load dec_pc with redirect_pc and enter FLUSH, taking priority over push and pop.
REQ-023 On redirect, a head presented in the same cycle SHALL be discarded and not counted as accepted.
REQ-024 The block SHALL perform no push in FLUSH, giving one bubble cycle for the decompression stage to settle on the new dec_pc.
REQ-025 The block SHALL never push when full without a simultaneous pop, and SHALL never pop when empty.

Reset
REQ-026 While rst is high, the block SHALL hold state=IDLE, dec_pc=RESET_PC, pointers=0, occupancy=0, core_valid=0, core_instr=0, core_pc=0 and fetch_count=0, asynchronously and regardless of clk.
REQ-027 Reset asserted mid-operation SHALL discard all entries immediately, and the first push after release SHALL use RESET_PC.

Configuration
REQ-028 When macro FETCH_COUNT_EN is defined, the block SHALL add output port fetch_count, 32 bits, which increments by 1 on every pop, wraps at 2^32, is cleared only by rst and is not cleared by redirect.
REQ-029 When FETCH_COUNT_EN is undefined, the fetch_count port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-030 Scenario: decompression model returns 32'h10000000+dec_pc, core_ready=1, reset released -> core_pc sequence 0,1,2,3,..., core_instr 32'h10000000,32'h10000001,..., one per cycle after the first, with no gaps.
REQ-031 Scenario: core_ready=0 for 10 cycles -> exactly 4 entries (pcs 0-3) queued, dec_pc holds 4; then core_ready=1 -> pcs 0,1,2,3,4,... in order with no duplicates.
REQ-032 Scenario: queue full and core_ready=1 continuously -> occupancy stays 4, and each cycle pops one entry and pushes one entry.
REQ-033 Scenario: redirect=1, redirect_pc=32'h20 with 3 entries queued and core_ready=1 -> next cycle core_valid=0, dec_pc=32'h20, state FLUSH; the following valid head has core_pc=32'h20.
REQ-034 Scenario: rst pulsed between clock edges while 2 entries are queued -> core_valid falls without a clock edge, and dec_pc=RESET_PC.
REQ-035 Scenario: with FETCH_COUNT_EN defined, 10 handshakes followed by a redirect -> fetch_count=10, and it remains 10 after the redirect.
